// File: rtl/dma64_pkg.sv
// -----------------------------------------------------------------------------
// dma64_pkg
// Shared definitions for the 64-bit DMA ctrl/chnl protocol, used by the memory
// responder and by the tree accelerators that act as initiators.
//   DMA_SIZE_64  : the only legal beat-size encoding (8-byte beats)
//   DMA_DATA_W   : channel data width
//   dma_state_e  : responder burst state
// -----------------------------------------------------------------------------
package dma64_pkg;

  localparam logic [2:0] DMA_SIZE_64 = 3'b011;
  localparam int         DMA_DATA_W  = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } dma_state_e;

endpackage

// File: rtl/dma64_mem_responder_if.sv
// -----------------------------------------------------------------------------
// dma64_mem_responder_if
// DMA ctrl/chnl bundle between an initiator (master) and a responder (slave).
//   read ctrl   : valid/ready + index, length, size, user  (initiator -> resp)
//   read chnl   : valid/ready + 64-bit data                (resp -> initiator)
//   write ctrl  : valid/ready + index, length, size, user  (initiator -> resp)
//   write chnl  : valid/ready + 64-bit data                (initiator -> resp)
// -----------------------------------------------------------------------------
interface dma64_mem_responder_if;
  import dma64_pkg::*;

  logic                  dma_read_ctrl_valid;
  logic                  dma_read_ctrl_ready;
  logic [31:0]           dma_read_ctrl_data_index;
  logic [31:0]           dma_read_ctrl_data_length;
  logic [2:0]            dma_read_ctrl_data_size;
  logic [5:0]            dma_read_ctrl_data_user;
  logic                  dma_read_chnl_valid;
  logic                  dma_read_chnl_ready;
  logic [DMA_DATA_W-1:0] dma_read_chnl_data;

  logic                  dma_write_ctrl_valid;
  logic                  dma_write_ctrl_ready;
  logic [31:0]           dma_write_ctrl_data_index;
  logic [31:0]           dma_write_ctrl_data_length;
  logic [2:0]            dma_write_ctrl_data_size;
  logic [5:0]            dma_write_ctrl_data_user;
  logic                  dma_write_chnl_valid;
  logic                  dma_write_chnl_ready;
  logic [DMA_DATA_W-1:0] dma_write_chnl_data;

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_ctrl_data_user,
           dma_write_chnl_valid, dma_write_chnl_data,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
           dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
           dma_write_ctrl_data_size, dma_write_ctrl_data_user,
           dma_write_chnl_valid, dma_write_chnl_data,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
           dma_write_ctrl_ready, dma_write_chnl_ready
  );

endinterface

// File: rtl/dma64_rd_fifo.sv
// -----------------------------------------------------------------------------
// dma64_rd_fifo
// Two-entry 64-bit valid/ready buffer between the RAM read port and the read
// channel. Head entry drives the output, so data stays put while not popped.
//   clk, rst           : clock, synchronous active-low reset (empties buffer)
//   push_valid_i/data  : write side;  push_ready_o when a slot is (or becomes) free
//   pop_valid_o/data   : read side;   pop_ready_i consumes the head entry
//   count_o            : current occupancy 0..2
// -----------------------------------------------------------------------------
module dma64_rd_fifo
  import dma64_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid_i,
  input  logic [DMA_DATA_W-1:0] push_data_i,
  output logic                  push_ready_o,
  output logic                  pop_valid_o,
  output logic [DMA_DATA_W-1:0] pop_data_o,
  input  logic                  pop_ready_i,
  output logic [1:0]            count_o
);

  logic [DMA_DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push, pop;

  assign pop_valid_o  = (cnt_q != 2'd0);
  assign pop_data_o   = e0_q;
  assign count_o      = cnt_q;
  assign pop          = pop_valid_o & pop_ready_i;
  assign push_ready_o = (cnt_q != 2'd2) | pop;
  assign push         = push_valid_i & push_ready_o;

  // NOTE: every _d gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = push_data_i;
        else               e1_d = push_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          e0_d = push_data_i;
        end else begin
          e0_d = e1_q;
          e1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= 2'd0;
    else      cnt_q <= cnt_d;
  end

  // NOTE: data storage is deliberately not reset; the occupancy count decides
  // what is valid, and leaving storage unreset keeps it in plain registers/RAM.
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

endmodule

// File: rtl/dma64_mem_responder.sv
// -----------------------------------------------------------------------------
// dma64_mem_responder
// Responder end of the 64-bit DMA ctrl/chnl interface backed by an internal
// synchronous word memory. One read or write burst at a time; a host port
// preloads and inspects memory.
//   clk, rst         : clock, synchronous active-low reset
//   dma (slave)      : read/write ctrl + chnl handshakes
//   host_we/addr/wdata/rdata : host access; writes only in IDLE, rdata 1-cycle latency
//   busy             : burst in progress
//   rd_done, wr_done : pulse in the cycle of the last beat handshake
//   size_err         : sticky, set when a request with size != 3'b011 is accepted
// -----------------------------------------------------------------------------
module dma64_mem_responder
  import dma64_pkg::*;
#(
  parameter  int MEM_WORDS = 8192,
  localparam int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  dma64_mem_responder_if.slave  dma,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DMA_DATA_W-1:0] host_wdata,
  output logic [DMA_DATA_W-1:0] host_rdata,
  output logic                  busy,
  output logic                  rd_done,
  output logic                  wr_done,
  output logic                  size_err
);

  dma_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [31:0]           req_left_q, req_left_d;   // read beats not yet requested from RAM
  logic [31:0]           beat_left_q, beat_left_d; // beats not yet handshaken on the channel
  logic                  inflight_q, inflight_d;   // RAM read issued last cycle
  logic                  size_err_q, size_err_d;

  logic [DMA_DATA_W-1:0] mem [MEM_WORDS];
  logic [DMA_DATA_W-1:0] ram_rdata_q;
  logic [DMA_DATA_W-1:0] host_rdata_q;

  logic                  rd_issue;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [DMA_DATA_W-1:0] mem_wdata;

  logic                  fifo_pop, fifo_valid, fifo_push_ready;
  logic [DMA_DATA_W-1:0] fifo_data;
  logic [1:0]            fifo_count;
  logic [2:0]            rd_load;

  logic                  rd_accept, wr_accept, wr_beat;
  logic [31:0]           req_idx, req_len;
  logic [2:0]            req_size;
  logic                  unused_bits;

  // Read wins when both requests are presented in the same IDLE cycle.
  assign rd_accept = (state_q == IDLE) & dma.dma_read_ctrl_valid;
  assign wr_accept = (state_q == IDLE) & ~dma.dma_read_ctrl_valid & dma.dma_write_ctrl_valid;
  assign req_idx   = dma.dma_read_ctrl_valid ? dma.dma_read_ctrl_data_index
                                             : dma.dma_write_ctrl_data_index;
  assign req_len   = dma.dma_read_ctrl_valid ? dma.dma_read_ctrl_data_length
                                             : dma.dma_write_ctrl_data_length;
  assign req_size  = dma.dma_read_ctrl_valid ? dma.dma_read_ctrl_data_size
                                             : dma.dma_write_ctrl_data_size;
  assign wr_beat   = (state_q == WR_BURST) & dma.dma_write_chnl_valid;
  assign fifo_pop  = fifo_valid & dma.dma_read_chnl_ready;

  // Buffer slots already spoken for after this cycle: occupancy plus the word
  // arriving from RAM, minus the beat leaving now. Counting the pop lets a new
  // read issue every cycle while the initiator keeps ready high.
  assign rd_load = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    req_left_d  = req_left_q;
    beat_left_d = beat_left_q;
    size_err_d  = size_err_q;
    rd_issue    = 1'b0;
    rd_addr     = ptr_q;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = dma.dma_write_chnl_data;
    rd_done     = 1'b0;
    wr_done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (host_we) begin
          mem_we    = 1'b1;
          mem_waddr = host_addr;
          mem_wdata = host_wdata;
        end
        if (rd_accept || wr_accept) begin
          if (req_size != DMA_SIZE_64) size_err_d = 1'b1;
          if (req_len != 32'd0) begin
            beat_left_d = req_len;
            if (rd_accept) begin
              // The first word is fetched in the accept cycle itself, which
              // puts the first beat on the channel two cycles after accept.
              rd_issue   = 1'b1;
              rd_addr    = req_idx[ADDR_W-1:0];
              ptr_d      = req_idx[ADDR_W-1:0] + ADDR_W'(1);
              req_left_d = req_len - 32'd1;
              state_d    = RD_BURST;
            end else begin
              ptr_d   = req_idx[ADDR_W-1:0];
              state_d = WR_BURST;
            end
          end
        end
      end

      RD_BURST: begin
        if (req_left_q != 32'd0 && rd_load < 3'd2) begin
          rd_issue   = 1'b1;
          ptr_d      = ptr_q + ADDR_W'(1);
          req_left_d = req_left_q - 32'd1;
        end
        if (fifo_pop) begin
          beat_left_d = beat_left_q - 32'd1;
          if (beat_left_q == 32'd1) begin
            rd_done = 1'b1;
            state_d = IDLE;
          end
        end
      end

      WR_BURST: begin
        if (wr_beat) begin
          mem_we      = 1'b1;
          ptr_d       = ptr_q + ADDR_W'(1);
          beat_left_d = beat_left_q - 32'd1;
          if (beat_left_q == 32'd1) begin
            wr_done = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    inflight_d = rd_issue;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      req_left_q  <= '0;
      beat_left_q <= '0;
      inflight_q  <= 1'b0;
      size_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      req_left_q  <= req_left_d;
      beat_left_q <= beat_left_d;
      inflight_q  <= inflight_d;
      size_err_q  <= size_err_d;
    end
  end

  // Read-first RAM: both reads see the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    ram_rdata_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst) host_rdata_q <= '0;
    else      host_rdata_q <= mem[host_addr];
  end

  dma64_rd_fifo u_rd_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (inflight_q),
    .push_data_i  (ram_rdata_q),
    .push_ready_o (fifo_push_ready),
    .pop_valid_o  (fifo_valid),
    .pop_data_o   (fifo_data),
    .pop_ready_i  (dma.dma_read_chnl_ready),
    .count_o      (fifo_count)
  );

  assign dma.dma_read_ctrl_ready  = (state_q == IDLE);
  assign dma.dma_write_ctrl_ready = (state_q == IDLE);
  assign dma.dma_read_chnl_valid  = fifo_valid;
  assign dma.dma_read_chnl_data   = fifo_data;
  assign dma.dma_write_chnl_ready = (state_q == WR_BURST);

  assign busy       = (state_q != IDLE);
  assign size_err   = size_err_q;
  assign host_rdata = host_rdata_q;

  // Upper index bits and user fields carry no meaning for this responder;
  // the prefetch rule guarantees a free slot, so push_ready is not consulted.
  assign unused_bits = ^{req_idx[31:ADDR_W], dma.dma_read_ctrl_data_user,
                         dma.dma_write_ctrl_data_user, fifo_push_ready};

endmodule

// File: tb/tb_dma64_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_dma64_mem_responder
// Drives the responder through directed and randomized bursts and compares the
// channel traffic, done pulses, flags and memory contents against a word-array
// model of the memory.
// -----------------------------------------------------------------------------
module tb_dma64_mem_responder;
  import dma64_pkg::*;

  localparam int MW = 8192;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [63:0]   host_wdata;
  logic [63:0]   host_rdata;
  logic          busy, rd_done, wr_done, size_err;

  always #5 clk = ~clk;

  dma64_mem_responder_if dma_if ();

  dma64_mem_responder #(.MEM_WORDS(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .dma        (dma_if),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .busy       (busy),
    .rd_done    (rd_done),
    .wr_done    (wr_done),
    .size_err   (size_err)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] model_mem [MW];
  bit          model_size_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic host_wr(input int addr, input logic [63:0] data);
    @(negedge clk);
    host_we    = 1'b1;
    host_addr  = AW'(addr);
    host_wdata = data;
    @(negedge clk);
    host_we = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic host_chk(input int addr);
    @(negedge clk);
    host_addr = AW'(addr);
    @(negedge clk);
    #1;
    check("host_rd", host_rdata, model_mem[addr]);
  endtask

  // Read burst. mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random.
  // Stops after max_beats handshakes. A nonzero wr_len also raises a write
  // request in the same cycle as the read request.
  task automatic do_read(input logic [31:0] idx, input int len, input logic [2:0] sz,
                         input int mode, input int max_beats, input bit poke,
                         input logic [31:0] wr_idx, input int wr_len);
    int          base, beats, cyc;
    bit          pv, pr, exp_done;
    logic [63:0] held;
    base = int'(idx[AW-1:0]);
    beats = 0; cyc = 0; pv = 0; pr = 0; held = '0;
    @(negedge clk);
    dma_if.dma_read_ctrl_valid       = 1'b1;
    dma_if.dma_read_ctrl_data_index  = idx;
    dma_if.dma_read_ctrl_data_length = len;
    dma_if.dma_read_ctrl_data_size   = sz;
    dma_if.dma_read_ctrl_data_user   = 6'($urandom);
    if (wr_len > 0) begin
      dma_if.dma_write_ctrl_valid       = 1'b1;
      dma_if.dma_write_ctrl_data_index  = wr_idx;
      dma_if.dma_write_ctrl_data_length = wr_len;
      dma_if.dma_write_ctrl_data_size   = DMA_SIZE_64;
    end
    #1;
    check("rd_ctrl_ready", dma_if.dma_read_ctrl_ready, 1'b1);
    if (sz != DMA_SIZE_64) model_size_err = 1'b1;
    while (beats < len && beats < max_beats && cyc < 200) begin
      @(negedge clk);
      cyc++;
      dma_if.dma_read_ctrl_valid = 1'b0;
      case (mode)
        0:       dma_if.dma_read_chnl_ready = 1'b1;
        1:       dma_if.dma_read_chnl_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: dma_if.dma_read_chnl_ready = 1'($urandom_range(0, 1));
      endcase
      host_we = poke && (cyc == 3);
      if (host_we) begin
        host_addr  = AW'(base);
        host_wdata = ~model_mem[base];
      end
      #1;
      check("rd_busy", {busy, dma_if.dma_read_ctrl_ready, dma_if.dma_write_ctrl_ready}, 3'b100);
      if (cyc == 1) check("rd_first_cycle_idle", dma_if.dma_read_chnl_valid, 1'b0);
      if (cyc == 2) check("rd_first_beat_lat", dma_if.dma_read_chnl_valid, 1'b1);
      if (mode == 0 && cyc > 2) check("rd_no_bubble", dma_if.dma_read_chnl_valid, 1'b1);
      if (pv && !pr) begin
        check("rd_hold_valid", dma_if.dma_read_chnl_valid, 1'b1);
        check("rd_hold_data", dma_if.dma_read_chnl_data, held);
      end
      exp_done = dma_if.dma_read_chnl_valid && dma_if.dma_read_chnl_ready && (beats == len - 1);
      check("rd_done", rd_done, exp_done);
      if (dma_if.dma_read_chnl_valid && dma_if.dma_read_chnl_ready) begin
        check("rd_data", dma_if.dma_read_chnl_data, model_mem[(base + beats) % MW]);
        beats++;
      end
      pv   = dma_if.dma_read_chnl_valid;
      pr   = dma_if.dma_read_chnl_ready;
      held = dma_if.dma_read_chnl_data;
    end
    host_we = 1'b0;
    if (beats < len && beats < max_beats) check("rd_timeout_beats", beats, len);
    if (beats == len) begin
      @(negedge clk);
      dma_if.dma_read_chnl_ready = 1'b0;
      #1;
      check("rd_end_state", {busy, dma_if.dma_read_chnl_valid, rd_done,
                             dma_if.dma_read_ctrl_ready, dma_if.dma_write_ctrl_ready}, 5'b00011);
      if (poke) host_chk(base);
    end
  endtask

  // Write burst with random valid gaps. With pre_acc the request is already
  // being accepted at the coming edge. The host port watches the address being
  // written and must return the word from before each write.
  task automatic do_write(input logic [31:0] idx, input int len, input logic [2:0] sz,
                          input bit pre_acc);
    int          base, beats, cyc;
    bit          have_prev;
    logic [63:0] prev_exp, cur;
    base = int'(idx[AW-1:0]);
    beats = 0; cyc = 0; have_prev = 0; prev_exp = '0;
    if (!pre_acc) begin
      @(negedge clk);
      dma_if.dma_write_chnl_valid       = 1'b1;
      dma_if.dma_write_ctrl_valid       = 1'b1;
      dma_if.dma_write_ctrl_data_index  = idx;
      dma_if.dma_write_ctrl_data_length = len;
      dma_if.dma_write_ctrl_data_size   = sz;
      dma_if.dma_write_ctrl_data_user   = 6'($urandom);
      #1;
      check("wr_ctrl_ready", dma_if.dma_write_ctrl_ready, 1'b1);
      check("wr_chnl_ready_idle", dma_if.dma_write_chnl_ready, 1'b0);
    end
    if (sz != DMA_SIZE_64) model_size_err = 1'b1;
    while (beats < len && cyc < 200) begin
      @(negedge clk);
      cyc++;
      dma_if.dma_write_ctrl_valid = 1'b0;
      dma_if.dma_write_chnl_valid = ($urandom_range(0, 3) != 0);
      dma_if.dma_write_chnl_data  = {$urandom, $urandom};
      host_addr = AW'((base + beats) % MW);
      cur = model_mem[(base + beats) % MW];
      #1;
      check("wr_state", {busy, dma_if.dma_write_chnl_ready, dma_if.dma_write_ctrl_ready}, 3'b110);
      if (have_prev) check("wr_host_read_first", host_rdata, prev_exp);
      check("wr_done", wr_done, dma_if.dma_write_chnl_valid && (beats == len - 1));
      if (dma_if.dma_write_chnl_valid) begin
        model_mem[(base + beats) % MW] = dma_if.dma_write_chnl_data;
        beats++;
      end
      prev_exp  = cur;
      have_prev = 1'b1;
    end
    if (beats < len) check("wr_timeout_beats", beats, len);
    // A stray beat after the burst must be refused and must not reach memory.
    @(negedge clk);
    dma_if.dma_write_chnl_valid = 1'b1;
    dma_if.dma_write_chnl_data  = {$urandom, $urandom};
    #1;
    check("wr_end_state", {busy, dma_if.dma_write_chnl_ready, wr_done}, 3'b000);
    @(negedge clk);
    dma_if.dma_write_chnl_valid = 1'b0;
    for (int i = 0; i <= len; i++) host_chk((base + i) % MW);
  endtask

  initial begin
    logic [31:0] ridx;
    int          rbase, rlen;
    logic [2:0]  rsz;

    dma_if.dma_read_ctrl_valid        = 1'b0;
    dma_if.dma_read_ctrl_data_index   = '0;
    dma_if.dma_read_ctrl_data_length  = '0;
    dma_if.dma_read_ctrl_data_size    = DMA_SIZE_64;
    dma_if.dma_read_ctrl_data_user    = '0;
    dma_if.dma_read_chnl_ready        = 1'b0;
    dma_if.dma_write_ctrl_valid       = 1'b0;
    dma_if.dma_write_ctrl_data_index  = '0;
    dma_if.dma_write_ctrl_data_length = '0;
    dma_if.dma_write_ctrl_data_size   = DMA_SIZE_64;
    dma_if.dma_write_ctrl_data_user   = '0;
    dma_if.dma_write_chnl_valid       = 1'b0;
    dma_if.dma_write_chnl_data        = '0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {busy, rd_done, wr_done, size_err, dma_if.dma_read_chnl_valid,
                            dma_if.dma_write_chnl_ready, dma_if.dma_read_ctrl_ready,
                            dma_if.dma_write_ctrl_ready}, 8'b0000_0011);
    check("reset_host_rdata", host_rdata, 64'd0);
    rst = 1'b1;

    // Preload the low region and the top of memory through the host port
    for (int i = 0; i < 32; i++) host_wr(i, (i < 8) ? 64'h100 + 64'(i) : {$urandom, $urandom});
    for (int i = MW - 8; i < MW; i++) host_wr(i, {$urandom, $urandom});
    host_chk(0);
    host_chk(7);
    host_chk(MW - 1);

    // Sequential read, ready held high
    do_read(32'd0, 8, DMA_SIZE_64, 0, 8, 1'b0, 32'd0, 0);
    check("size_err_clean", size_err, model_size_err);

    // Same read with ready toggling 1,0,0,1
    do_read(32'd0, 8, DMA_SIZE_64, 1, 8, 1'b0, 32'd0, 0);

    // Write wrapping from the top of memory to address 0
    do_write(32'(MW - 2), 4, DMA_SIZE_64, 1'b0);
    do_read(32'(MW - 2), 4, DMA_SIZE_64, 2, 4, 1'b0, 32'd0, 0);

    // Read and write requested together: read first, write right after rd_done
    do_read(32'd8, 5, DMA_SIZE_64, 2, 5, 1'b0, 32'd20, 3);
    do_write(32'd20, 3, DMA_SIZE_64, 1'b1);

    // Zero-length read: nothing on the channel, no done, stays idle
    do_read(32'd4, 0, DMA_SIZE_64, 0, 0, 1'b0, 32'd0, 0);
    dma_if.dma_read_chnl_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("len0_idle", {busy, dma_if.dma_read_chnl_valid, rd_done,
                          dma_if.dma_read_ctrl_ready}, 4'b0001);
    end

    // Illegal size: flag sticks, burst still runs as 64-bit
    do_read(32'd2, 4, 3'b010, 0, 4, 1'b0, 32'd0, 0);
    check("size_err_set", size_err, model_size_err);
    do_read(32'd10, 3, DMA_SIZE_64, 2, 3, 1'b0, 32'd0, 0);
    check("size_err_sticky", size_err, model_size_err);

    // Reset after 3 of 8 beats
    do_read(32'd0, 8, DMA_SIZE_64, 0, 3, 1'b0, 32'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    dma_if.dma_read_chnl_ready = 1'b0;
    @(negedge clk);
    #1;
    model_size_err = 1'b0;
    check("midburst_reset", {busy, dma_if.dma_read_chnl_valid, rd_done, size_err,
                             dma_if.dma_read_ctrl_ready, dma_if.dma_write_ctrl_ready}, 6'b000011);
    rst = 1'b1;
    do_read(32'd3, 6, DMA_SIZE_64, 0, 6, 1'b0, 32'd0, 0);

    // Host writes during a burst are ignored
    do_read(32'd5, 8, DMA_SIZE_64, 2, 8, 1'b1, 32'd0, 0);

    // Randomized bursts over the preloaded regions, upper index bits random
    for (int n = 0; n < 16; n++) begin
      rbase = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : MW - int'($urandom_range(1, 8));
      rlen  = int'($urandom_range(1, 12));
      ridx  = 32'(rbase) + 32'(MW) * 32'($urandom_range(0, 100000));
      rsz   = ($urandom_range(0, 7) == 0) ? 3'b010 : DMA_SIZE_64;
      if ($urandom_range(0, 1) == 0)
        do_read(ridx, rlen, rsz, int'($urandom_range(0, 2)), rlen, 1'b0, 32'd0, 0);
      else
        do_write(ridx, rlen, rsz, 1'b0);
      check("rand_size_err", size_err, model_size_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
